// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN core's timestep scheduler.
package snn_pkg;

    localparam int NUM_NEURONS_DEFAULT     = 256;
    localparam int NEURON_IDX_W            = $clog2(NUM_NEURONS_DEFAULT);
    localparam int POTENTIAL_WIDTH_DEFAULT = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        DONE
    } sched_state_t;

    typedef logic [NEURON_IDX_W-1:0] spike_event_t;

endpackage

// File: rtl/spike_fifo.sv
// First-word-fall-through event queue; full/empty come from a registered occupancy count.
module spike_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head is forced to zero when empty so the output is clean after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/neuron_scheduler.sv
// Timestep sequencer: latches axons on tick, walks every neuron through read/eval/write, queues spikes.
module neuron_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS     = 256,
    parameter int NUM_AXONS       = 256,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           tick_i,
    input  logic [NUM_AXONS-1:0]           axon_in_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overrun_o,
    output logic                           mem_rd_en_o,
    output logic [$clog2(NUM_NEURONS)-1:0] mem_addr_o,
    output logic                           pot_we_o,
    output logic [POTENTIAL_WIDTH-1:0]     pot_wdata_o,
    output logic [NUM_AXONS-1:0]           nb_axon_o,
    input  logic [POTENTIAL_WIDTH-1:0]     nb_write_potential_i,
    input  logic                           nb_spike_i,
    output logic                           spike_valid_o,
    input  logic                           spike_ready_i,
    output logic [$clog2(NUM_NEURONS)-1:0] spike_neuron_o
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_N = IDX_W'(NUM_NEURONS - 1);

    sched_state_t               state;
    logic [IDX_W-1:0]           n;
    logic [NUM_AXONS-1:0]       axon_q;
    logic [POTENTIAL_WIDTH-1:0] pot_q;
    logic                       spike_q;
    logic                       overrun_q;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       write_go;
    logic                       push;

    // A spiking neuron may only commit its write-back once its event has a FIFO slot.
    assign write_go = (state == WRITE) && !(spike_q && fifo_full);
    assign push     = write_go && spike_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            n         <= '0;
            axon_q    <= '0;
            pot_q     <= '0;
            spike_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (tick_i && state != IDLE) overrun_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        axon_q <= axon_in_i;
                        n      <= '0;
                        state  <= READ;
                    end
                end
                READ: state <= EVAL;
                EVAL: begin
                    pot_q   <= nb_write_potential_i;
                    spike_q <= nb_spike_i;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (write_go) begin
                        if (n == LAST_N) begin
                            state <= DONE;
                        end else begin
                            n     <= n + IDX_W'(1);
                            state <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registers only; nothing from spike_ready_i reaches the FSM.
    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign mem_rd_en_o   = (state == READ);
    assign mem_addr_o    = n;
    assign pot_we_o      = write_go;
    assign pot_wdata_o   = pot_q;
    assign nb_axon_o     = axon_q;
    assign overrun_o     = overrun_q;
    assign spike_valid_o = !fifo_empty;

    spike_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (n),
        .pop       (spike_valid_o && spike_ready_i),
        .pop_data  (spike_neuron_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
